// File: rtl/wb_regfile.sv
// Write-back end of the pipeline: selects memory/ALU result, commits it into the
// 32-entry architectural register file, and serves two decode read ports with bypass.
module wb_regfile #(
    parameter int DATA_W = 32,
    parameter int NREG   = 32
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              RegWrite_i,
    input  logic              MemToReg_i,
    input  logic [DATA_W-1:0] Mem_data_i,
    input  logic [DATA_W-1:0] ALU_data_i,
    input  logic [5:0]        RegWriteAddr_i,
    input  logic [4:0]        RdAddrA_i,
    input  logic [4:0]        RdAddrB_i,
    output logic [DATA_W-1:0] RdDataA_o,
    output logic [DATA_W-1:0] RdDataB_o,
    output logic [DATA_W-1:0] WbData_o,
    output logic [31:0]       WrCount_o,
    output logic              BadAddr_o
);

    localparam int AW = 5;

    logic [DATA_W-1:0] regs_q [NREG];
    logic [31:0]       wr_count_q, wr_count_d;
    logic              bad_addr_q, bad_addr_d;

    logic [DATA_W-1:0] wb_data;
    logic [AW-1:0]     wr_idx;
    logic              commit;
    logic              bad_set;

    assign wb_data = MemToReg_i ? Mem_data_i : ALU_data_i;
    assign wr_idx  = RegWriteAddr_i[AW-1:0];
    // Bit 5 of the destination flags an out-of-range register; index 0 is hardwired zero.
    assign commit  = RegWrite_i & ~RegWriteAddr_i[AW] & (wr_idx != '0);
    assign bad_set = RegWrite_i & RegWriteAddr_i[AW];

    always_comb begin
        wr_count_d = wr_count_q;
        bad_addr_d = bad_addr_q;
        if (commit) begin
            wr_count_d = wr_count_q + 32'd1;
        end
        if (bad_set) begin
            bad_addr_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
            wr_count_q <= '0;
            bad_addr_q <= 1'b0;
        end else begin
            if (commit) begin
                regs_q[wr_idx] <= wb_data;
            end
            wr_count_q <= wr_count_d;
            bad_addr_q <= bad_addr_d;
        end
    end

    // Both read ports share one structure: zero, then same-cycle bypass, then array.
    logic [AW-1:0]     rd_addr [2];
    logic [DATA_W-1:0] rd_data [2];

    assign rd_addr[0] = RdAddrA_i;
    assign rd_addr[1] = RdAddrB_i;

    for (genvar gi = 0; gi < 2; gi++) begin : g_rd_port
        assign rd_data[gi] = (rd_addr[gi] == '0)                 ? '0      :
                             (commit && (wr_idx == rd_addr[gi])) ? wb_data :
                                                                   regs_q[rd_addr[gi]];
    end

    assign RdDataA_o = rd_data[0];
    assign RdDataB_o = rd_data[1];
    assign WbData_o  = wb_data;
    assign WrCount_o = wr_count_q;
    assign BadAddr_o = bad_addr_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: one task per scenario, inline comparisons.
module tb_wb_regfile;

    logic        clk_i;
    logic        rst_n_i;
    logic        RegWrite_i;
    logic        MemToReg_i;
    logic [31:0] Mem_data_i;
    logic [31:0] ALU_data_i;
    logic [5:0]  RegWriteAddr_i;
    logic [4:0]  RdAddrA_i;
    logic [4:0]  RdAddrB_i;
    logic [31:0] RdDataA_o;
    logic [31:0] RdDataB_o;
    logic [31:0] WbData_o;
    logic [31:0] WrCount_o;
    logic        BadAddr_o;

    int checks   = 0;
    int failures = 0;

    wb_regfile #(.DATA_W(32), .NREG(32)) dut (
        .clk_i          (clk_i),
        .rst_n_i        (rst_n_i),
        .RegWrite_i     (RegWrite_i),
        .MemToReg_i     (MemToReg_i),
        .Mem_data_i     (Mem_data_i),
        .ALU_data_i     (ALU_data_i),
        .RegWriteAddr_i (RegWriteAddr_i),
        .RdAddrA_i      (RdAddrA_i),
        .RdAddrB_i      (RdAddrB_i),
        .RdDataA_o      (RdDataA_o),
        .RdDataB_o      (RdDataB_o),
        .WbData_o       (WbData_o),
        .WrCount_o      (WrCount_o),
        .BadAddr_o      (BadAddr_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Drives one write-back at a negedge, lets it cross a posedge, then drops RegWrite_i.
    task automatic do_write(input logic m2r, input logic [5:0] addr,
                            input logic [31:0] mem, input logic [31:0] alu);
        @(negedge clk_i);
        RegWrite_i     = 1'b1;
        MemToReg_i     = m2r;
        RegWriteAddr_i = addr;
        Mem_data_i     = mem;
        ALU_data_i     = alu;
        @(posedge clk_i);
        #1;
        RegWrite_i = 1'b0;
        #1;
        $display("txn write addr=%h m2r=%0d mem=%h alu=%h count=%0d bad=%0d",
                 addr, m2r, mem, alu, WrCount_o, BadAddr_o);
    endtask

    task automatic test_reset();
        rst_n_i        = 1'b0;
        RegWrite_i     = 1'b0;
        MemToReg_i     = 1'b0;
        Mem_data_i     = '0;
        ALU_data_i     = '0;
        RegWriteAddr_i = '0;
        RdAddrA_i      = '0;
        RdAddrB_i      = '0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_n_i = 1'b1;
        for (int i = 0; i < 32; i++) begin
            RdAddrA_i = 5'(i);
            RdAddrB_i = 5'(31 - i);
            #1;
            checks++;
            if (RdDataA_o !== 32'h0 || RdDataB_o !== 32'h0) begin
                failures++;
                $display("FAIL reset_read idx=%0d got A=%h B=%h required 0", i, RdDataA_o, RdDataB_o);
            end
        end
        checks++;
        if (WrCount_o !== 32'd0) begin
            failures++;
            $display("FAIL reset_count got=%0d required=0", WrCount_o);
        end
        checks++;
        if (BadAddr_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_bad got=%0d required=0", BadAddr_o);
        end
        $display("txn reset done count=%0d bad=%0d", WrCount_o, BadAddr_o);
    endtask

    task automatic test_mux_write();
        @(negedge clk_i);
        MemToReg_i = 1'b1;
        Mem_data_i = 32'hDEADBEEF;
        ALU_data_i = 32'h12345678;
        #1;
        checks++;
        if (WbData_o !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL mux_mem got=%h required=deadbeef", WbData_o);
        end
        MemToReg_i = 1'b0;
        #1;
        checks++;
        if (WbData_o !== 32'h12345678) begin
            failures++;
            $display("FAIL mux_alu got=%h required=12345678", WbData_o);
        end
        do_write(1'b1, 6'd5, 32'hDEADBEEF, 32'h12345678);
        RdAddrA_i = 5'd5;
        #1;
        checks++;
        if (RdDataA_o !== 32'hDEADBEEF || WrCount_o !== 32'd1) begin
            failures++;
            $display("FAIL write_mem got data=%h count=%0d required deadbeef 1", RdDataA_o, WrCount_o);
        end
        do_write(1'b0, 6'd5, 32'hDEADBEEF, 32'h12345678);
        #1;
        checks++;
        if (RdDataA_o !== 32'h12345678 || WrCount_o !== 32'd2) begin
            failures++;
            $display("FAIL write_alu got data=%h count=%0d required 12345678 2", RdDataA_o, WrCount_o);
        end
    endtask

    task automatic test_bypass();
        do_write(1'b0, 6'd7, 32'h0, 32'h01020304);
        @(negedge clk_i);
        RdAddrA_i      = 5'd7;
        RdAddrB_i      = 5'd7;
        RegWrite_i     = 1'b0;
        MemToReg_i     = 1'b1;
        Mem_data_i     = 32'hCAFEF00D;
        RegWriteAddr_i = 6'd7;
        #1;
        checks++;
        if (RdDataA_o !== 32'h01020304 || RdDataB_o !== 32'h01020304) begin
            failures++;
            $display("FAIL bypass_disabled got A=%h B=%h required 01020304", RdDataA_o, RdDataB_o);
        end
        RegWrite_i = 1'b1;
        #1;
        checks++;
        if (RdDataA_o !== 32'hCAFEF00D || RdDataB_o !== 32'hCAFEF00D) begin
            failures++;
            $display("FAIL bypass_both got A=%h B=%h required cafef00d", RdDataA_o, RdDataB_o);
        end
        RdAddrB_i = 5'd5;
        #1;
        checks++;
        if (RdDataA_o !== 32'hCAFEF00D || RdDataB_o !== 32'h12345678) begin
            failures++;
            $display("FAIL bypass_split got A=%h B=%h required cafef00d 12345678", RdDataA_o, RdDataB_o);
        end
        @(posedge clk_i);
        #1;
        RegWrite_i = 1'b0;
        RdAddrB_i  = 5'd7;
        #1;
        checks++;
        if (RdDataA_o !== 32'hCAFEF00D || RdDataB_o !== 32'hCAFEF00D || WrCount_o !== 32'd4) begin
            failures++;
            $display("FAIL bypass_commit got A=%h B=%h count=%0d required cafef00d cafef00d 4",
                     RdDataA_o, RdDataB_o, WrCount_o);
        end
        $display("txn bypass reg7 A=%h B=%h count=%0d", RdDataA_o, RdDataB_o, WrCount_o);
    endtask

    task automatic test_zero_reg();
        @(negedge clk_i);
        RdAddrA_i      = 5'd0;
        RdAddrB_i      = 5'd0;
        RegWrite_i     = 1'b1;
        MemToReg_i     = 1'b0;
        ALU_data_i     = 32'hFFFFFFFF;
        RegWriteAddr_i = 6'd0;
        #1;
        checks++;
        if (RdDataA_o !== 32'h0 || RdDataB_o !== 32'h0) begin
            failures++;
            $display("FAIL zero_no_bypass got A=%h B=%h required 0", RdDataA_o, RdDataB_o);
        end
        @(posedge clk_i);
        #1;
        RegWrite_i = 1'b0;
        #1;
        checks++;
        if (RdDataA_o !== 32'h0 || WrCount_o !== 32'd4 || BadAddr_o !== 1'b0) begin
            failures++;
            $display("FAIL zero_write got A=%h count=%0d bad=%0d required 0 4 0",
                     RdDataA_o, WrCount_o, BadAddr_o);
        end
        $display("txn zero-reg write count=%0d", WrCount_o);
    endtask

    task automatic test_bad_addr();
        @(negedge clk_i);
        RdAddrA_i      = 5'd5;
        RegWrite_i     = 1'b1;
        MemToReg_i     = 1'b0;
        ALU_data_i     = 32'h11111111;
        RegWriteAddr_i = 6'h25;
        #1;
        checks++;
        if (RdDataA_o !== 32'h12345678) begin
            failures++;
            $display("FAIL bad_no_bypass got=%h required=12345678", RdDataA_o);
        end
        @(posedge clk_i);
        #1;
        RegWrite_i = 1'b0;
        #1;
        checks++;
        if (RdDataA_o !== 32'h12345678 || BadAddr_o !== 1'b1 || WrCount_o !== 32'd4) begin
            failures++;
            $display("FAIL bad_write got reg5=%h bad=%0d count=%0d required 12345678 1 4",
                     RdDataA_o, BadAddr_o, WrCount_o);
        end
        do_write(1'b1, 6'd9, 32'h00000099, 32'h0);
        RdAddrA_i = 5'd9;
        #1;
        checks++;
        if (RdDataA_o !== 32'h00000099 || BadAddr_o !== 1'b1 || WrCount_o !== 32'd5) begin
            failures++;
            $display("FAIL bad_sticky got reg9=%h bad=%0d count=%0d required 99 1 5",
                     RdDataA_o, BadAddr_o, WrCount_o);
        end
        @(negedge clk_i);
        rst_n_i = 1'b0;
        #1;
        RdAddrA_i = 5'd5;
        #1;
        checks++;
        if (BadAddr_o !== 1'b0 || WrCount_o !== 32'd0 || RdDataA_o !== 32'h0) begin
            failures++;
            $display("FAIL bad_reset got bad=%0d count=%0d reg5=%h required 0 0 0",
                     BadAddr_o, WrCount_o, RdDataA_o);
        end
        @(negedge clk_i);
        rst_n_i = 1'b1;
        $display("txn illegal-address sequence bad=%0d count=%0d", BadAddr_o, WrCount_o);
    endtask

    task automatic test_reset_mid();
        do_write(1'b1, 6'd3, 32'hA5A5A5A5, 32'h0);
        RdAddrA_i = 5'd3;
        #1;
        checks++;
        if (RdDataA_o !== 32'hA5A5A5A5 || WrCount_o !== 32'd1) begin
            failures++;
            $display("FAIL mid_pre got reg3=%h count=%0d required a5a5a5a5 1", RdDataA_o, WrCount_o);
        end
        @(negedge clk_i);
        #2;
        rst_n_i = 1'b0;
        #1;
        checks++;
        if (RdDataA_o !== 32'h0 || WrCount_o !== 32'd0) begin
            failures++;
            $display("FAIL mid_async got reg3=%h count=%0d required 0 0", RdDataA_o, WrCount_o);
        end
        RegWrite_i     = 1'b1;
        MemToReg_i     = 1'b0;
        ALU_data_i     = 32'h00000077;
        RegWriteAddr_i = 6'd3;
        @(posedge clk_i);
        #1;
        RegWrite_i = 1'b0;
        #1;
        checks++;
        if (RdDataA_o !== 32'h0 || WrCount_o !== 32'd0) begin
            failures++;
            $display("FAIL mid_discard got reg3=%h count=%0d required 0 0", RdDataA_o, WrCount_o);
        end
        @(negedge clk_i);
        rst_n_i = 1'b1;
        do_write(1'b0, 6'd4, 32'h0, 32'h00000044);
        RdAddrA_i = 5'd4;
        RdAddrB_i = 5'd3;
        #1;
        checks++;
        if (RdDataA_o !== 32'h00000044 || RdDataB_o !== 32'h0 || WrCount_o !== 32'd1) begin
            failures++;
            $display("FAIL mid_release got reg4=%h reg3=%h count=%0d required 44 0 1",
                     RdDataA_o, RdDataB_o, WrCount_o);
        end
        $display("txn mid-cycle reset sequence count=%0d", WrCount_o);
    endtask

    task automatic test_back_to_back();
        logic [31:0] vals [3];
        vals[0] = 32'h1010AAAA;
        vals[1] = 32'h2121BBBB;
        vals[2] = 32'h3232CCCC;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            RegWrite_i     = 1'b1;
            MemToReg_i     = (i % 2 == 0);
            Mem_data_i     = vals[i];
            ALU_data_i     = vals[i];
            RegWriteAddr_i = 6'(10 + i);
        end
        @(negedge clk_i);
        RegWrite_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            RdAddrA_i = 5'(10 + i);
            RdAddrB_i = 5'(12 - i);
            #1;
            checks++;
            if (RdDataA_o !== vals[i] || RdDataB_o !== vals[2 - i]) begin
                failures++;
                $display("FAIL b2b idx=%0d got A=%h B=%h required %h %h",
                         10 + i, RdDataA_o, RdDataB_o, vals[i], vals[2 - i]);
            end
        end
        checks++;
        if (WrCount_o !== 32'd4) begin
            failures++;
            $display("FAIL b2b_count got=%0d required=4", WrCount_o);
        end
        $display("txn back-to-back writes count=%0d", WrCount_o);
    endtask

    initial begin
        test_reset();
        test_mux_write();
        test_bypass();
        test_zero_reg();
        test_bad_addr();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
